// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
//
// Instruction-fetch stage of the pipelined LC-3b core. It owns the program
// counter, issues instruction-memory reads using a read/resp handshake, and
// writes {PC+2, instruction} into the IF/ID pipeline latch.
//
// A one-entry hold buffer absorbs a downstream stall that lands on a response
// cycle. Control-flow redirects are accepted at any time. A redirect that
// arrives while a read is outstanding cannot abort that read, so its target
// is parked until the response comes back and is then thrown away.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   I_addr       instruction-memory read address
//   I_read       instruction-memory read request
//   I_rdata      instruction-memory read data, valid when I_resp=1
//   I_resp       one-cycle pulse: read complete
//   stall        IF/ID must not load this cycle
//   redirect     one-cycle pulse: replace the fetch PC
//   redirect_pc  redirect target (bit 0 forced to 0)
//   PC_reg_out   PC+2 of the delivered instruction, to IF/ID
//   I_rdata_out  delivered instruction, to IF/ID
//   load_if_id   IF/ID load enable
//   valid_out    PC_reg_out/I_rdata_out hold a real instruction
// ----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] I_addr,
  output logic        I_read,
  input  logic [15:0] I_rdata,
  input  logic        I_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] PC_reg_out,
  output logic [15:0] I_rdata_out,
  output logic        load_if_id,
  output logic        valid_out
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] hold_pc;
  logic [15:0] hold_instr;
  logic [15:0] tgt;

  logic [15:0] pc_plus2;
  logic [15:0] redirect_tgt;
  logic [15:0] reset_pc_even;

  // Instructions are halfword aligned, so the low address bit is always zero.
  // The +2 wraps naturally in 16 bits (0xFFFE -> 0x0000).
  assign pc_plus2      = pc + 16'd2;
  assign redirect_tgt  = {redirect_pc[15:1], 1'b0};
  assign reset_pc_even = {RESET_PC[15:1], 1'b0};

  // Output decode. I_addr always shows pc: in FETCH and DISCARD that keeps the
  // address stable for the whole outstanding request, because pc only moves
  // on the response cycle. Everything else is forced quiet during reset.
  always_comb begin
    I_addr      = pc;
    I_read      = 1'b0;
    PC_reg_out  = 16'h0000;
    I_rdata_out = 16'h0000;
    load_if_id  = 1'b0;
    valid_out   = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          I_read      = 1'b1;
          PC_reg_out  = pc_plus2;
          I_rdata_out = I_rdata;
          // A response squashed by a same-cycle redirect is never presented
          // as a real instruction.
          if (I_resp && !redirect) begin
            valid_out  = 1'b1;
            load_if_id = !stall;
          end
        end
        HOLD: begin
          PC_reg_out  = hold_pc;
          I_rdata_out = hold_instr;
          if (!redirect) begin
            valid_out  = 1'b1;
            load_if_id = !stall;
          end
        end
        DISCARD: begin
          I_read = 1'b1;
        end
        default: begin
          I_read = 1'b0;
        end
      endcase
    end
  end

  // Fetch state machine. In DISCARD, a redirect arriving on the response
  // cycle wins over the parked target so the most recent redirect is honoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= reset_pc_even;
      state      <= FETCH;
      hold_pc    <= 16'h0000;
      hold_instr <= 16'h0000;
      tgt        <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (I_resp) begin
            if (redirect) begin
              pc <= redirect_tgt;
            end else if (stall) begin
              hold_pc    <= pc_plus2;
              hold_instr <= I_rdata;
              state      <= HOLD;
            end else begin
              pc <= pc_plus2;
            end
          end else if (redirect) begin
            tgt   <= redirect_tgt;
            state <= DISCARD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= redirect_tgt;
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc_plus2;
            state <= FETCH;
          end
        end
        DISCARD: begin
          if (I_resp) begin
            pc    <= redirect ? redirect_tgt : tgt;
            state <= FETCH;
          end else if (redirect) begin
            tgt <= redirect_tgt;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ----------------------------------------------------------------------------
// tb_if_fetch
//
// Bench for if_fetch. The main instance (RESET_PC = 0) is driven from a table
// of per-cycle vectors; each vector gives the inputs for one cycle and the
// outputs expected in that cycle. Every vector that expects an IF/ID load
// pushes the expected {PC+2, instruction} onto a queue, and an independent
// monitor pops and compares whenever the DUT actually asserts load_if_id.
// A second instance with RESET_PC = 16'hFFFE covers the PC wrap.
// ----------------------------------------------------------------------------
module tb_if_fetch;

  typedef struct {
    logic        rst;
    logic        resp;
    logic [15:0] rdata;
    logic        stl;
    logic        redir;
    logic [15:0] rpc;
    logic [15:0] e_addr;
    logic        e_read;
    logic        e_load;
    logic        e_valid;
    logic        chk_data;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_t;

  logic        clk;
  logic        reset;
  logic [15:0] I_addr;
  logic        I_read;
  logic [15:0] I_rdata;
  logic        I_resp;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] PC_reg_out;
  logic [15:0] I_rdata_out;
  logic        load_if_id;
  logic        valid_out;

  logic [15:0] I_addr2;
  logic        I_read2;
  logic [15:0] I_rdata2;
  logic        I_resp2;
  logic        stall2;
  logic        redirect2;
  logic [15:0] redirect_pc2;
  logic [15:0] PC_reg_out2;
  logic [15:0] I_rdata_out2;
  logic        load_if_id2;
  logic        valid_out2;

  int checks;
  int failures;
  vec_t vq[$];
  sb_t  sbq[$];

  if_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .I_addr(I_addr), .I_read(I_read),
    .I_rdata(I_rdata), .I_resp(I_resp), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .PC_reg_out(PC_reg_out),
    .I_rdata_out(I_rdata_out), .load_if_id(load_if_id), .valid_out(valid_out)
  );

  if_fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .I_addr(I_addr2), .I_read(I_read2),
    .I_rdata(I_rdata2), .I_resp(I_resp2), .stall(stall2),
    .redirect(redirect2), .redirect_pc(redirect_pc2),
    .PC_reg_out(PC_reg_out2), .I_rdata_out(I_rdata_out2),
    .load_if_id(load_if_id2), .valid_out(valid_out2)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every real IF/ID load must match the oldest expected
  // delivery, and a load with nothing expected is itself an error.
  always @(negedge clk) begin
    if (load_if_id === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected_load: got pc=%h instr=%h, required no load",
                 PC_reg_out, I_rdata_out);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        if (PC_reg_out !== e.pc || I_rdata_out !== e.instr) begin
          failures++;
          $display("[TB] FAIL sb_delivery: got pc=%h instr=%h, required pc=%h instr=%h",
                   PC_reg_out, I_rdata_out, e.pc, e.instr);
        end
      end
    end
  end

  function automatic vec_t mk(
    input logic rst, input logic resp, input logic [15:0] rdata,
    input logic stl, input logic redir, input logic [15:0] rpc,
    input logic [15:0] e_addr, input logic e_read, input logic e_load,
    input logic e_valid, input logic chk_data, input logic [15:0] e_pc,
    input logic [15:0] e_instr);
    vec_t v;
    v.rst = rst;       v.resp = resp;       v.rdata = rdata;
    v.stl = stl;       v.redir = redir;     v.rpc = rpc;
    v.e_addr = e_addr; v.e_read = e_read;   v.e_load = e_load;
    v.e_valid = e_valid; v.chk_data = chk_data;
    v.e_pc = e_pc;     v.e_instr = e_instr;
    return v;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; a vector that
  // expects a load hands its delivery to the scoreboard.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    reset       = v.rst;
    I_resp      = v.resp;
    I_rdata     = v.rdata;
    stall       = v.stl;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    if (v.e_load) begin
      sb_t e;
      e.pc    = v.e_pc;
      e.instr = v.e_instr;
      sbq.push_back(e);
    end
  endtask

  // Compare at the falling edge, well away from the active edge.
  task automatic checkOutput(input vec_t v, input int idx);
    @(negedge clk);
    check1($sformatf("v%0d I_read", idx), I_read, v.e_read);
    if (v.e_read) check16($sformatf("v%0d I_addr", idx), I_addr, v.e_addr);
    check1($sformatf("v%0d load_if_id", idx), load_if_id, v.e_load);
    check1($sformatf("v%0d valid_out", idx), valid_out, v.e_valid);
    if (v.chk_data) begin
      check16($sformatf("v%0d PC_reg_out", idx), PC_reg_out, v.e_pc);
      check16($sformatf("v%0d I_rdata_out", idx), I_rdata_out, v.e_instr);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    I_resp = 1'b0;
    I_rdata = 16'h0000;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    I_resp2 = 1'b0;
    I_rdata2 = 16'h0000;
    stall2 = 1'b0;
    redirect2 = 1'b0;
    redirect_pc2 = 16'h0000;
    repeat (2) @(posedge clk);

    //          rst resp rdata     stl rdr rpc        addr      rd ld vl cd pc        instr
    // reset state, all outputs quiet
    vq.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000));
    // back-to-back fetch with 1-cycle memory
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 16'h1111, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h0002, 16'h1111));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0002, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 16'h2222, 0, 0, 16'h0000, 16'h0002, 1, 1, 1, 1, 16'h0004, 16'h2222));
    // redirect coincident with response: squashed, next fetch at 0x0100
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0004, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 16'h3333, 0, 1, 16'h0100, 16'h0004, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0100, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 16'h4444, 0, 1, 16'h0010, 16'h0100, 1, 0, 0, 0, 16'h0000, 16'h0000));
    // stall 3 cycles on the response of fetch @0x0010
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0010, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 16'hABCD, 1, 0, 16'h0000, 16'h0010, 1, 0, 1, 1, 16'h0012, 16'hABCD));
    vq.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0012, 16'hABCD));
    vq.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h0012, 16'hABCD));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 1, 16'h0012, 16'hABCD));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0012, 1, 0, 0, 0, 16'h0000, 16'h0000));
    // redirect while in HOLD with stall=1: buffer dropped
    vq.push_back(mk(0, 1, 16'h5555, 1, 0, 16'h0000, 16'h0012, 1, 0, 1, 1, 16'h0014, 16'h5555));
    vq.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0040, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000));
    // redirect to 0x0301 during a 4-cycle read @0x0040
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0040, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0301, 16'h0040, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0040, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 16'h6666, 0, 0, 16'h0000, 16'h0040, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0300, 1, 0, 0, 0, 16'h0000, 16'h0000));
    // latest redirect wins in DISCARD, including one on the response cycle
    vq.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0500, 16'h0300, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0601, 16'h0300, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 16'h9999, 0, 1, 16'h0702, 16'h0300, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0702, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 16'h7777, 0, 0, 16'h0000, 16'h0702, 1, 1, 1, 1, 16'h0704, 16'h7777));
    // reset asserted while in DISCARD
    vq.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0900, 16'h0704, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 16'h1234, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 1, 16'h0002, 16'h1234));

    foreach (vq[i]) begin
      applyStimulus(vq[i]);
      checkOutput(vq[i], i);
    end

    @(posedge clk);
    #1;
    I_resp = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;

    // Wrap instance: reset it cleanly, then one fetch at 0xFFFE.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check1("wrap I_read", I_read2, 1'b1);
    check16("wrap I_addr first", I_addr2, 16'hFFFE);
    @(posedge clk);
    #1;
    I_resp2 = 1'b1;
    I_rdata2 = 16'hBEEF;
    @(negedge clk);
    check1("wrap load_if_id", load_if_id2, 1'b1);
    check16("wrap PC_reg_out", PC_reg_out2, 16'h0000);
    check16("wrap I_rdata_out", I_rdata_out2, 16'hBEEF);
    @(posedge clk);
    #1;
    I_resp2 = 1'b0;
    @(negedge clk);
    check16("wrap I_addr second", I_addr2, 16'h0000);
    check1("wrap load idle", load_if_id2, 1'b0);

    // Every expected delivery must have been consumed by a real load.
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_drained: got %0d pending deliveries, required 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
